// File: rtl/riscv_writeback_stage.sv
// MEM/WB register and writeback stage: load alignment, source mux, regfile write.
// Optional retired-instruction counter enabled by RISCV_WB_INSTRET_EN.
module riscv_writeback_stage #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_mem_valid,
  output logic            o_mem_ready,
  input  logic            i_mem_rd_wen,
  input  logic [4:0]      i_mem_rd_addr,
  input  logic [1:0]      i_mem_wb_sel,
  input  logic [2:0]      i_mem_funct3,
  input  logic [XLEN-1:0] i_mem_alu_result,
  input  logic [XLEN-1:0] i_mem_pc_plus4,
  input  logic            i_dmem_rvalid,
  input  logic [XLEN-1:0] i_dmem_rdata,
  output logic            o_regfile_rd_wen,
  output logic [4:0]      o_regfile_rd_addr,
  output logic [XLEN-1:0] o_regfile_rd_data,
`ifdef RISCV_WB_INSTRET_EN
  output logic [63:0]     o_wb_instret,
`endif
  output logic            o_wb_retire
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOLD      = 2'd1,
    WAIT_LOAD = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              rd_wen_q;
  logic [4:0]        rd_addr_q;
  logic [1:0]        wb_sel_q;
  logic [2:0]        funct3_q;
  logic [XLEN-1:0]   alu_q;
  logic [XLEN-1:0]   pc4_q;

  logic              fire;
  logic [XLEN-1:0]   shifted;
  logic [15:0]       half;
  logic [XLEN-1:0]   ld_data;
  logic [XLEN-1:0]   wb_data;

  assign o_mem_ready = (state_q != WAIT_LOAD) || i_dmem_rvalid;

  // Gating with reset keeps a pending load from writing in the reset cycle.
  assign fire = !i_rst &&
                ((state_q == HOLD) ||
                 (state_q == WAIT_LOAD && i_dmem_rvalid));

  assign shifted = i_dmem_rdata >> {alu_q[1:0], 3'b000};
  assign half    = alu_q[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];

  always_comb begin
    ld_data = i_dmem_rdata;
    case (funct3_q)
      3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  ld_data = {24'd0, shifted[7:0]};
      3'b001:  ld_data = {{16{half[15]}}, half};
      3'b101:  ld_data = {16'd0, half};
      default: ld_data = i_dmem_rdata;
    endcase
  end

  always_comb begin
    wb_data = '0;
    case (wb_sel_q)
      2'b00:   wb_data = alu_q;
      2'b01:   wb_data = ld_data;
      2'b10:   wb_data = pc4_q;
      default: wb_data = '0;
    endcase
  end

  assign o_regfile_rd_wen  = fire && rd_wen_q && (rd_addr_q != 5'd0);
  assign o_regfile_rd_addr = rd_addr_q;
  assign o_regfile_rd_data = wb_data;
  assign o_wb_retire       = fire;

  always_comb begin
    state_d = state_q;
    if (o_mem_ready) begin
      if (!i_mem_valid)
        state_d = IDLE;
      else if (i_mem_wb_sel == 2'b01)
        state_d = WAIT_LOAD;
      else
        state_d = HOLD;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      rd_wen_q  <= 1'b0;
      rd_addr_q <= '0;
      wb_sel_q  <= '0;
      funct3_q  <= '0;
      alu_q     <= '0;
      pc4_q     <= '0;
    end else begin
      state_q <= state_d;
      if (o_mem_ready && i_mem_valid) begin
        rd_wen_q  <= i_mem_rd_wen;
        rd_addr_q <= i_mem_rd_addr;
        wb_sel_q  <= i_mem_wb_sel;
        funct3_q  <= i_mem_funct3;
        alu_q     <= i_mem_alu_result;
        pc4_q     <= i_mem_pc_plus4;
      end
    end
  end

`ifdef RISCV_WB_INSTRET_EN
  logic [63:0] instret_q;

  always_ff @(posedge i_clk) begin
    if (i_rst)
      instret_q <= '0;
    else if (o_wb_retire)
      instret_q <= instret_q + 64'd1;
  end

  assign o_wb_instret = instret_q;
`endif

endmodule

// File: tb/tb_riscv_writeback_stage.sv
// Self-checking bench for riscv_writeback_stage: directed plan plus random traffic.
// A transaction-level model predicts every write, stall and retirement.
module tb_riscv_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_rd_wen;
  logic [4:0]  mem_rd_addr;
  logic [1:0]  mem_wb_sel;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_alu;
  logic [31:0] mem_pc4;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        rf_wen;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        retire;
`ifdef RISCV_WB_INSTRET_EN
  logic [63:0] instret;
`endif

  always #5 clk = ~clk;

  riscv_writeback_stage dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_mem_valid       (mem_valid),
    .o_mem_ready       (mem_ready),
    .i_mem_rd_wen      (mem_rd_wen),
    .i_mem_rd_addr     (mem_rd_addr),
    .i_mem_wb_sel      (mem_wb_sel),
    .i_mem_funct3      (mem_funct3),
    .i_mem_alu_result  (mem_alu),
    .i_mem_pc_plus4    (mem_pc4),
    .i_dmem_rvalid     (dmem_rvalid),
    .i_dmem_rdata      (dmem_rdata),
    .o_regfile_rd_wen  (rf_wen),
    .o_regfile_rd_addr (rf_addr),
    .o_regfile_rd_data (rf_data),
`ifdef RISCV_WB_INSTRET_EN
    .o_wb_instret      (instret),
`endif
    .o_wb_retire       (retire)
  );

  typedef struct {
    bit        wen;
    bit [4:0]  rd;
    bit [1:0]  sel;
    bit [2:0]  f3;
    bit [31:0] alu;
    bit [31:0] pc4;
  } instr_t;

  instr_t      held[$];
  longint unsigned n_retired;
  int          checks   = 0;
  int          failures = 0;
  logic        obs_wen, obs_ret, obs_rdy;
  logic [31:0] obs_data;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit [31:0] load_val(input bit [2:0] f3,
                                         input bit [31:0] addr,
                                         input bit [31:0] word);
    bit [31:0] v;
    case (f3)
      3'd0, 3'd4: begin
        v = (word >> (8 * addr[1:0])) % 256;
        if (f3 == 3'd0 && v >= 128) v = v + 32'hFFFF_FF00;
      end
      3'd1, 3'd5: begin
        v = (word >> (16 * addr[1])) % 65536;
        if (f3 == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  task automatic cyc(input bit r, input bit v, input bit w,
                     input bit [4:0] rd, input bit [1:0] sel,
                     input bit [2:0] f3, input bit [31:0] alu,
                     input bit [31:0] pc4, input bit rv,
                     input bit [31:0] rdata);
    bit        busy, is_ld, e_rdy, e_fire;
    bit [31:0] e_data;
    instr_t    h;
    @(negedge clk);
    rst = r; mem_valid = v; mem_rd_wen = w; mem_rd_addr = rd;
    mem_wb_sel = sel; mem_funct3 = f3; mem_alu = alu; mem_pc4 = pc4;
    dmem_rvalid = rv; dmem_rdata = rdata;
    #2;
    busy   = held.size() != 0;
    if (busy) h = held[0];
    is_ld  = busy && h.sel == 2'd1;
    e_rdy  = !is_ld || rv;
    e_fire = !r && busy && (!is_ld || rv);
    obs_wen = rf_wen; obs_ret = retire; obs_rdy = mem_ready;
    obs_data = rf_data;
    chk("ready", mem_ready, e_rdy);
    chk("retire", retire, e_fire);
    chk("wen", rf_wen, e_fire && h.wen && h.rd != 0);
    if (e_fire) begin
      case (h.sel)
        2'd0: e_data = h.alu;
        2'd1: e_data = load_val(h.f3, h.alu, rdata);
        2'd2: e_data = h.pc4;
        default: e_data = 0;
      endcase
      chk("addr", rf_addr, h.rd);
      chk("data", rf_data, e_data);
    end
`ifdef RISCV_WB_INSTRET_EN
    chk("instret", instret, n_retired);
`endif
    @(posedge clk);
    if (r) begin
      held.delete();
      n_retired = 0;
    end else begin
      if (e_fire) n_retired++;
      if (e_rdy) begin
        held.delete();
        if (v) held.push_back('{w, rd, sel, f3, alu, pc4});
      end
    end
  endtask

  task automatic idle(input bit rv, input bit [31:0] rdata);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, rv, rdata);
  endtask

  task automatic load_test(input bit [2:0] f3, input bit [31:0] addr,
                           input bit [31:0] word, input bit [31:0] exp);
    cyc(0, 1, 1, 5'd7, 2'd1, f3, addr, 0, 0, 0);
    idle(0, 0);
    chk("ld_stall", obs_rdy, 0);
    idle(0, 0);
    idle(1, word);
    chk("ld_wen", obs_wen, 1);
    chk("ld_data", obs_data, exp);
  endtask

  initial begin
    n_retired = 0;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 0);
    chk("rst_wen", obs_wen, 0);
    chk("rst_ready", obs_rdy, 1);
    chk("rst_retire", obs_ret, 0);
`ifdef RISCV_WB_INSTRET_EN
    chk("instret_rst", instret, 0);
`endif

    cyc(0, 1, 1, 5'd5, 2'd0, 0, 32'h0000_1234, 0, 0, 0);
    idle(0, 0);
    chk("alu_wen", obs_wen, 1);
    chk("alu_data", obs_data, 32'h0000_1234);
    chk("alu_retire", obs_ret, 1);

    load_test(3'd0, 32'h103, 32'h80FF_1122, 32'hFFFF_FF80);
    load_test(3'd4, 32'h103, 32'h80FF_1122, 32'h0000_0080);
    load_test(3'd1, 32'h102, 32'h9ABC_0000, 32'hFFFF_9ABC);
    load_test(3'd5, 32'h102, 32'h9ABC_0000, 32'h0000_9ABC);

    cyc(0, 1, 1, 5'd1, 2'd2, 0, 0, 32'h40, 0, 0);
    idle(0, 0);
    chk("jal_data", obs_data, 32'h40);

    cyc(0, 1, 1, 5'd0, 2'd0, 0, 32'hDEAD_BEEF, 0, 0, 0);
    idle(0, 0);
    chk("x0_wen", obs_wen, 0);
    chk("x0_retire", obs_ret, 1);

    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 1, 5'(i + 10), 2'd0, 0, 32'(i * 3 + 1), 0, 0, 0);
      if (i > 0) chk("b2b_wen", obs_wen, 1);
    end
    idle(0, 0);
    chk("b2b_last", obs_data, 32'd7);

    cyc(0, 1, 1, 5'd9, 2'd1, 3'd2, 32'h200, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1, 32'h1111_2222);
    chk("rst_ld_wen", obs_wen, 0);
    chk("rst_ld_retire", obs_ret, 0);
`ifdef RISCV_WB_INSTRET_EN
    chk("instret_zero", instret, 0);
    for (int i = 0; i < 3; i++)
      cyc(0, 1, 1, 5'd3, 2'd0, 0, 32'(i), 0, 0, 0);
    idle(0, 0);
    chk("instret_three", instret, 3);
`endif

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 60) == 0, ($urandom % 10) < 7, 1'($urandom),
          5'($urandom), 2'($urandom), 3'($urandom), $urandom,
          $urandom, ($urandom % 10) < 4, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
